idex_skid: RTL

- Parametrised ID/EX pipeline register with a valid/ready handshake, a one-entry skid buffer, synchronous flush, and load-use hazard detection.
- Sits between the decode and execute stages.
- Stalls in execute no longer lose decoded instructions.
- A load followed by a dependent instruction automatically gets a one-cycle bubble.

---
 rtl/idex_skid_if.sv | 48 ++++
 rtl/idex_skid.sv | 118 +++++++++++
 2 files changed

// File: rtl/idex_skid_if.sv
// ID/EX handshake bundle: upstream valid/ready with the decoded payload, downstream valid/ready
// with the registered payload, plus flush, hazard and statistics lines.
interface idex_skid_if #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int SW = 8,
  parameter int CW = 16
);
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_busA;
  logic [DW-1:0] i_busB;
  logic [DW-1:0] i_imm32;
  logic [RW-1:0] i_rd;
  logic [RW-1:0] i_rs;
  logic [RW-1:0] i_rt;
  logic          i_rt_used;
  logic [SW-1:0] i_signals;
  logic          i_lw;
  logic          i_flush;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_busA;
  logic [DW-1:0] o_busB;
  logic [DW-1:0] o_imm32;
  logic [RW-1:0] o_rd;
  logic [SW-1:0] o_signals;
  logic          o_lw;
  logic          o_hazard;
  logic [CW-1:0] o_stall_cnt;
  logic [CW-1:0] o_flush_cnt;

  // Decode/execute side driving the stage.
  modport master (
    output i_valid, i_busA, i_busB, i_imm32, i_rd, i_rs, i_rt, i_rt_used, i_signals, i_lw,
           i_flush, i_ready,
    input  o_ready, o_valid, o_busA, o_busB, o_imm32, o_rd, o_signals, o_lw, o_hazard,
           o_stall_cnt, o_flush_cnt
  );

  // The pipeline register itself.
  modport slave (
    input  i_valid, i_busA, i_busB, i_imm32, i_rd, i_rs, i_rt, i_rt_used, i_signals, i_lw,
           i_flush, i_ready,
    output o_ready, o_valid, o_busA, o_busB, o_imm32, o_rd, o_signals, o_lw, o_hazard,
           o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/idex_skid.sv
// ID/EX pipeline register with one-entry skid buffer, flush and load-use bubble insertion.
// Optional saturating stall/flush counters are built when IDEX_STATS_EN is defined.
module idex_skid #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int SW = 8,
  parameter int CW = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  idex_skid_if.slave   bus
);
  localparam int PW = 3*DW + RW + SW + 1;

  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] m_data_reg, s_data_reg, in_data;
  logic          load_m_in, load_m_skid, load_s;
  logic          m_valid, s_valid, down, accept, ready_int, hazard;
  logic [RW-1:0] m_rd;
  logic          m_lw;

  // Payload layout: {busA, busB, imm32, rd, signals, lw}
  assign in_data = {bus.i_busA, bus.i_busB, bus.i_imm32, bus.i_rd, bus.i_signals, bus.i_lw};
  assign m_rd    = m_data_reg[SW+1 +: RW];
  assign m_lw    = m_data_reg[0];

  assign m_valid   = (state_reg != EMPTY);
  assign s_valid   = (state_reg == SKID);
  assign hazard    = bus.i_valid & m_valid & m_lw & (m_rd != '0) &
                     ((m_rd == bus.i_rs) | (bus.i_rt_used & (m_rd == bus.i_rt)));
  assign ready_int = ~s_valid & ~hazard;
  assign accept    = bus.i_valid & ready_int;
  assign down      = m_valid & bus.i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= EMPTY;
      m_data_reg <= '0;
      s_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (load_m_in)
        m_data_reg <= in_data;
      else if (load_m_skid)
        m_data_reg <= s_data_reg;
      if (load_s)
        s_data_reg <= in_data;
    end
  end

  always_comb begin
    state_next  = state_reg;
    load_m_in   = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          state_next = FULL;
          load_m_in  = 1'b1;
        end
      end
      FULL: begin
        if (accept && down) begin
          load_m_in = 1'b1;
        end else if (accept) begin
          state_next = SKID;
          load_s     = 1'b1;
        end else if (down) begin
          state_next = EMPTY;
        end
      end
      SKID: begin
        if (down) begin
          state_next  = FULL;
          load_m_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
    // Flush drops everything held and discards any same-cycle accept; data stays stale.
    if (bus.i_flush) begin
      state_next  = EMPTY;
      load_m_in   = 1'b0;
      load_m_skid = 1'b0;
      load_s      = 1'b0;
    end
  end

  assign bus.o_ready  = ready_int;
  assign bus.o_valid  = m_valid;
  assign bus.o_hazard = hazard;
  assign {bus.o_busA, bus.o_busB, bus.o_imm32, bus.o_rd, bus.o_signals, bus.o_lw} = m_data_reg;

`ifdef IDEX_STATS_EN
  logic [CW-1:0] stall_cnt_reg, flush_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (bus.i_valid && !ready_int && !bus.i_flush && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (bus.i_flush && m_valid && (flush_cnt_reg != '1))
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign bus.o_stall_cnt = stall_cnt_reg;
  assign bus.o_flush_cnt = flush_cnt_reg;
`else
  assign bus.o_stall_cnt = {CW{1'b0}};
  assign bus.o_flush_cnt = {CW{1'b0}};
`endif
endmodule
